uart_apb_initiator: RTL

APB3 master that converts a simple valid/ready request stream into single APB3 transfers and returns each result on a valid/ready response channel. It sits on the bus side of the UART register map, as the initiator end of the same APB3 link. Typical drivers are a test sequencer, a bridge from a host command channel, or an on-chip boot engine programming `UART_BIT_LENGTH`/`CTRL` and moving bytes through DFIFO/UFIFO. The block issues exactly one outstanding transfer at a time and optionally bounds the access phase with a timeout.

---
 rtl/uart_apb_initiator.sv | 131 +++++++++++++
 1 files changed

// File: rtl/uart_apb_initiator.sv
// uart_apb_initiator: turns a valid/ready request stream into single APB3 transfers with a response channel.
// Optional ACCESS-phase timeout is built when UART_APB_INITIATOR_TIMEOUT_EN is defined.
module uart_apb_initiator #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      i_apb_pclk,
    input  logic                      i_apb_presetn,
    input  logic                      i_req_valid,
    output logic                      o_req_ready,
    input  logic                      i_req_write,
    input  logic [APB_ADDR_WIDTH-1:0] i_req_addr,
    input  logic [APB_DATA_WIDTH-1:0] i_req_wdata,
    output logic                      o_rsp_valid,
    input  logic                      i_rsp_ready,
    output logic [APB_DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                      o_rsp_err,
    output logic                      o_rsp_timeout,
    output logic [APB_ADDR_WIDTH-1:0] o_apb_paddr,
    output logic [APB_DATA_WIDTH-1:0] o_apb_pwdata,
    output logic                      o_apb_pwrite,
    output logic                      o_apb_psel,
    output logic                      o_apb_penable,
    input  logic                      i_apb_pready,
    input  logic [APB_DATA_WIDTH-1:0] i_apb_prdata,
    input  logic                      i_apb_pslverr,
    output logic                      o_busy,
    output logic [7:0]                o_err_cnt
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                    state_q, state_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d, rdata_q, rdata_d;
    logic                      pwrite_q, pwrite_d, err_q, err_d;
    logic [7:0]                err_cnt_q, err_cnt_d;
    logic                      accept, expire, finish;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("uart_apb_initiator: TIMEOUT_CYCLES must be >= 2");
    end

    assign accept = (state_q == IDLE) && i_req_valid;
    assign finish = (state_q == ACCESS) && (i_apb_pready || expire);

`ifdef UART_APB_INITIATOR_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo_q, tmo_d;

    // pready in the expiry cycle wins, so expiry requires pready low
    assign expire        = (state_q == ACCESS) && !i_apb_pready && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign cnt_d         = accept ? '0 : ((state_q == ACCESS) && !i_apb_pready) ? cnt_q + 1'b1 : cnt_q;
    assign tmo_d         = finish ? !i_apb_pready : tmo_q;
    assign o_rsp_timeout = tmo_q;

    always_ff @(posedge i_apb_pclk or negedge i_apb_presetn) begin
        if (!i_apb_presetn) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end
`else
    assign expire        = 1'b0;
    assign o_rsp_timeout = 1'b0;
`endif

    always_ff @(posedge i_apb_pclk or negedge i_apb_presetn) begin
        if (!i_apb_presetn) state_q <= IDLE;
        else                state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = i_req_valid ? SETUP : IDLE;
            SETUP:   state_d = ACCESS;
            ACCESS:  state_d = finish ? RESP : ACCESS;
            RESP:    state_d = i_rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    // ready is gated by reset so every output reads 0 while reset is held
    always_comb begin
        o_req_ready   = i_apb_presetn && (state_q == IDLE);
        o_apb_psel    = (state_q == SETUP) || (state_q == ACCESS);
        o_apb_penable = state_q == ACCESS;
        o_rsp_valid   = state_q == RESP;
        o_busy        = state_q != IDLE;
    end

    always_comb begin
        paddr_d   = accept ? i_req_addr : paddr_q;
        pwdata_d  = accept ? i_req_wdata : pwdata_q;
        pwrite_d  = accept ? i_req_write : pwrite_q;
        rdata_d   = finish ? ((i_apb_pready && !pwrite_q) ? i_apb_prdata : '0) : rdata_q;
        err_d     = finish ? (!i_apb_pready || i_apb_pslverr) : err_q;
        err_cnt_d = (finish && err_d && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge i_apb_pclk or negedge i_apb_presetn) begin
        if (!i_apb_presetn) begin
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pwrite_q  <= pwrite_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign o_apb_paddr  = paddr_q;
    assign o_apb_pwdata = pwdata_q;
    assign o_apb_pwrite = pwrite_q;
    assign o_rsp_rdata  = rdata_q;
    assign o_rsp_err    = err_q;
    assign o_err_cnt    = err_cnt_q;
endmodule
